// File: rtl/axi_common_pkg.sv
// Shared AXI helpers for the interconnect blocks.
// Index-width helper used to size encoder outputs.
package axi_common;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_id_alloc_prio_enc.sv
// Lowest-set-bit priority encoder.
// idx is 0 when no bit is set; qualify with any.
module prio_enc
  import axi_common::*;
#(
  parameter int WIDTH = 4,
  localparam int IW = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/axi_id_alloc.sv
// Wide-to-narrow AXI ID remapper with per-entry
// outstanding counters; same wide ID reuses its entry.
module axi_id_alloc
  import axi_common::*;
#(
  parameter int IN_ID_WIDTH  = 8,
  parameter int OUT_ID_WIDTH = 2,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  input  logic [IN_ID_WIDTH-1:0]  req_id,
  output logic                    req_ready,
  output logic [OUT_ID_WIDTH-1:0] req_out_id,
  input  logic                    rel_valid,
  input  logic [OUT_ID_WIDTH-1:0] rel_out_id,
  output logic [IN_ID_WIDTH-1:0]  rel_in_id,
  output logic                    full,
  output logic                    rel_err
);

  localparam int DEPTH = 2 ** OUT_ID_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [IN_ID_WIDTH-1:0] in_id;
    logic [CNT_WIDTH-1:0]   cnt;
  } entry_t;

  entry_t tbl_q [DEPTH];
  entry_t tbl_d [DEPTH];

  logic [DEPTH-1:0]        match;
  logic [DEPTH-1:0]        free;
  logic [OUT_ID_WIDTH-1:0] m_idx;
  logic [OUT_ID_WIDTH-1:0] f_idx;
  logic                    m_any;
  logic                    f_any;
  logic                    grant;
  logic                    rel_hit;
  logic                    rel_err_d;
  logic                    rel_err_q;

  always_comb begin
    match = '0;
    free  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free[i]  = (tbl_q[i].cnt == '0);
      match[i] = !free[i] && (tbl_q[i].in_id == req_id);
    end
  end

  prio_enc #(.WIDTH(DEPTH)) u_match (
    .req (match),
    .idx (m_idx),
    .any (m_any)
  );

  prio_enc #(.WIDTH(DEPTH)) u_free (
    .req (free),
    .idx (f_idx),
    .any (f_any)
  );

  // A live mapping must be reused even if a lower free slot exists,
  // otherwise same-ID ordering downstream would break.
  always_comb begin
    req_ready  = f_any;
    req_out_id = f_idx;
    if (m_any) begin
      req_ready  = (tbl_q[m_idx].cnt != CNT_MAX);
      req_out_id = m_idx;
    end
  end

  assign grant   = req_valid && req_ready;
  assign rel_hit = (tbl_q[rel_out_id].cnt != '0);

  always_comb begin
    logic inc;
    logic dec;
    for (int i = 0; i < DEPTH; i++) begin
      tbl_d[i] = tbl_q[i];
      inc = grant && (req_out_id == OUT_ID_WIDTH'(i));
      dec = rel_valid && (rel_out_id == OUT_ID_WIDTH'(i))
            && (tbl_q[i].cnt != '0);
      if (inc) tbl_d[i].in_id = req_id;
      if (inc && !dec)
        tbl_d[i].cnt = tbl_q[i].cnt + CNT_WIDTH'(1);
      else if (dec && !inc)
        tbl_d[i].cnt = tbl_q[i].cnt - CNT_WIDTH'(1);
    end
  end

  assign rel_err_d = rel_valid && !rel_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      rel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_d[i];
      rel_err_q <= rel_err_d;
    end
  end

  assign rel_in_id = tbl_q[rel_out_id].in_id;
  assign full      = !f_any;
  assign rel_err   = rel_err_q;

endmodule

// File: doc/axi_id_alloc.md
AXI_ID_ALLOC -- requirements
Module: axi_id_alloc

Interface
REQ-001 SHALL have parameter IN_ID_WIDTH, default 8, width of the wide (master-side) ID.
REQ-002 SHALL have parameter OUT_ID_WIDTH, default 2, width of the narrow (slave-side) ID; table depth is 2**OUT_ID_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 4, width of the per-entry outstanding counter.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  allocation request for req_id.
REQ-007 req_id  input  IN_ID_WIDTH  wide ID to map.
REQ-008 req_ready  output  1  request accepted this cycle.
REQ-009 req_out_id  output  OUT_ID_WIDTH  granted narrow ID; valid when req_valid && req_ready.
REQ-010 rel_valid  input  1  one transaction on rel_out_id completed; always accepted.
REQ-011 rel_out_id  input  OUT_ID_WIDTH  narrow ID being released.
REQ-012 rel_in_id  output  IN_ID_WIDTH  wide ID stored at entry rel_out_id (combinational lookup).
REQ-013 full  output  1  no entry free (every entry count != 0).
REQ-014 rel_err  output  1  registered one-cycle pulse: release hit an entry with count 0.

Function
REQ-015 Table entry SHALL hold in_id (IN_ID_WIDTH) and cnt (CNT_WIDTH); entry is free iff cnt == 0.
REQ-016 Match: an entry SHALL match when cnt != 0 and in_id == req_id; at most one entry matches by construction.
REQ-017 If a matching entry exists: req_ready = (cnt != 2**CNT_WIDTH-1), req_out_id = that index; a non-matching free entry SHALL NOT be used (preserves same-ID ordering).
REQ-018 If no match: req_ready = (any entry free), req_out_id = lowest-index free entry.
REQ-019 req_ready and req_out_id SHALL depend only on registered table state, req_valid and req_id; no dependency on rel_* inputs (no combinational path rel_* -> req_*).
REQ-020 On req_valid && req_ready: chosen entry in_id <= req_id, cnt <= cnt+1; zero latency, a grant is visible to lookup the next cycle.
REQ-021 On rel_valid with cnt != 0: entry rel_out_id cnt <= cnt-1; in_id retained.
REQ-022 On rel_valid with cnt == 0: table unchanged, rel_err = 1 next cycle.
REQ-023 Simultaneous grant and release on the same entry: cnt unchanged, in_id <= req_id (equal value on a match).
REQ-024 Entry freed by release in cycle N SHALL be allocatable from cycle N+1, not in cycle N.
REQ-025 Counter SHALL never wrap: saturation guarded by REQ-017; underflow guarded by REQ-022.
REQ-026 req_ready MAY be asserted with req_valid low; no state change without handshake.
REQ-027 rel_in_id SHALL be valid for any rel_out_id, regardless of rel_valid.

Reset
REQ-028 On rstn low, all entries SHALL clear to in_id = 0, cnt = 0 immediately, regardless of clk.
REQ-029 Reset outputs: full = 0, rel_err = 0, req_ready = req_valid-independent value 1 (table empty), req_out_id = 0, rel_in_id = 0.
REQ-030 Reset mid-operation SHALL discard all outstanding mappings; no handshake completes during reset.

Structure
REQ-031 Entry typedef (in_id, cnt) SHALL be parameterized locally; shared package axi_common SHALL gain only a width-check helper if needed, no new types.
REQ-032 One sub-module SHALL be used: prio_enc (lowest-set-bit encoder, parameter WIDTH, outputs index and any).
REQ-033 Table SHALL be flops (concurrent lookup on req_id, rel_out_id); no RAM inference.
REQ-034 Combinational depth on req path: one compare per entry + one priority encode.

Verification (defaults IN=8, OUT=2, CNT=4)
REQ-035 Reset, req_id=0x35 valid -> req_ready=1, req_out_id=0; next cycle entry0 {0x35,1}.
REQ-036 Requests 0x10,0x20,0x30,0x40 then 0x50 -> out_ids 0,1,2,3 granted, full=1, 0x50 stalled; rel_out_id=2 -> next cycle 0x50 granted out_id 2.
REQ-037 15 requests of 0x77 -> all to out_id 0, cnt=15; 16th -> req_ready=0 until one rel_valid on 0, then granted.
REQ-038 Entry1 {0xAA,1}: same cycle req 0xAA and rel_out_id=1 -> granted out_id 1, cnt stays 1, rel_in_id=0xAA.
REQ-039 Entry3 cnt=1, rel on 3 and req 0x99 same cycle with entries 0-2 busy -> req_ready=0 that cycle, granted out_id 3 next cycle.
REQ-040 rel_valid on free entry 2 -> rel_err pulses 1 cycle, table unchanged; assert rstn mid-burst -> all cnt 0, full=0 without clock edge.
